lot_gate_ctrl: RTL and testbench



---
 rtl/lot_gate_ctrl_if.sv | 26 ++
 rtl/lot_gate_ctrl.sv | 127 ++++++++++++
 tb/tb_lot_gate_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/lot_gate_ctrl_if.sv
// Gate controller bus: sensor/driver inputs and gate/occupancy outputs.
// master = sensor side (drives req/enter/exit), slave = controller.
interface lot_gate_ctrl_if #(
    parameter int unsigned CNT_W = 5
) ();
    logic             req;
    logic             enter;
    logic             exit;
    logic             gate_open;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             timeout_pulse;
    logic             err_unauth;
    logic             err_range;

    modport master (
        output req, enter, exit,
        input  gate_open, count, full, empty, timeout_pulse, err_unauth, err_range
    );

    modport slave (
        input  req, enter, exit,
        output gate_open, count, full, empty, timeout_pulse, err_unauth, err_range
    );
endinterface

// File: rtl/lot_gate_ctrl.sv
// Entry-gate sequencer and saturating occupancy tracker for the parking lot.
// CAPACITY must be in 1..2**CNT_W-1; TMR_W must hold max(TIMEOUT, GUARD).
module lot_gate_ctrl #(
    parameter int unsigned CAPACITY = 16,
    parameter int unsigned CNT_W    = 5,
    parameter int unsigned TIMEOUT  = 200,
    parameter int unsigned GUARD    = 4,
    parameter int unsigned TMR_W    = 8
) (
    input  logic           clk,
    input  logic           reset,
    lot_gate_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StOpen,
        StGuard
    } state_e;

    localparam logic [TMR_W-1:0] TimeoutLast = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] GuardLast   = TMR_W'(GUARD - 1);
    localparam logic [CNT_W-1:0] CapCount    = CNT_W'(CAPACITY);

    state_e           state_q;
    logic [TMR_W-1:0] timer_q;
    logic             gate_open_q;
    logic             timeout_pulse_q;
    logic [CNT_W-1:0] count_q;
    logic             err_unauth_q;
    logic             err_range_q;
    logic             full;
    logic             empty;

    // Occupancy flags decode straight from the registered count.
    always_comb begin
        full  = (count_q == CapCount);
        empty = (count_q == '0);
    end

    // Gate sequencer: timer and outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            timer_q         <= '0;
            gate_open_q     <= 1'b0;
            timeout_pulse_q <= 1'b0;
        end else begin
            timeout_pulse_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // A request at full is dropped, not queued.
                    if (bus.req && !full) begin
                        state_q     <= StOpen;
                        timer_q     <= '0;
                        gate_open_q <= 1'b1;
                    end
                end
                StOpen: begin
                    // enter wins over timeout on the same cycle.
                    if (bus.enter) begin
                        state_q     <= StGuard;
                        timer_q     <= '0;
                        gate_open_q <= 1'b0;
                    end else if (timer_q == TimeoutLast) begin
                        state_q         <= StGuard;
                        timer_q         <= '0;
                        gate_open_q     <= 1'b0;
                        timeout_pulse_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                StGuard: begin
                    if (timer_q == GuardLast) begin
                        state_q <= StIdle;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    timer_q     <= '0;
                    gate_open_q <= 1'b0;
                end
            endcase
        end
    end

    // Saturating occupancy count and sticky anomaly flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q      <= '0;
            err_unauth_q <= 1'b0;
            err_range_q  <= 1'b0;
        end else begin
            // Simultaneous enter and exit cancel out, even at a boundary.
            if (bus.enter && !bus.exit) begin
                if (full) begin
                    err_range_q <= 1'b1;
                end else begin
                    count_q <= count_q + CNT_W'(1);
                end
            end else if (bus.exit && !bus.enter) begin
                if (empty) begin
                    err_range_q <= 1'b1;
                end else begin
                    count_q <= count_q - CNT_W'(1);
                end
            end
            // Cars slipping in outside an open window are still counted.
            if (bus.enter && (state_q != StOpen)) begin
                err_unauth_q <= 1'b1;
            end
        end
    end

    assign bus.gate_open     = gate_open_q;
    assign bus.count         = count_q;
    assign bus.full          = full;
    assign bus.empty         = empty;
    assign bus.timeout_pulse = timeout_pulse_q;
    assign bus.err_unauth    = err_unauth_q;
    assign bus.err_range     = err_range_q;

endmodule

// File: tb/tb_lot_gate_ctrl.sv
// Self-checking bench for lot_gate_ctrl: vector table, directed corner
// sequences, then random traffic against a behavioural model.
module tb_lot_gate_ctrl;
    localparam int CAP = 16;
    localparam int TMO = 200;
    localparam int GRD = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    lot_gate_ctrl_if #(.CNT_W(5)) bus ();

    lot_gate_ctrl #(
        .CAPACITY(CAP),
        .CNT_W   (5),
        .TIMEOUT (TMO),
        .GUARD   (GRD),
        .TMR_W   (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Outputs packed as {gate_open, count[4:0], full, empty, tpulse, unauth, range}.
    typedef struct {
        logic [3:0]  in;   // {reset, req, enter, exit}
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[15];

    // Behavioural model: gate phase tracked as open age / guard cycles left.
    bit model_on = 1'b0;
    bit m_open;
    int m_age;
    int m_guard_left;
    int m_count;
    bit m_tp, m_eu, m_er;

    function automatic logic [10:0] act();
        return {bus.gate_open, bus.count, bus.full, bus.empty, bus.timeout_pulse,
                bus.err_unauth, bus.err_range};
    endfunction

    function automatic logic [10:0] e(input int go, input int c, input int tp,
                                      input int eu, input int er);
        return {1'(go), 5'(c), 1'(c == CAP), 1'(c == 0), 1'(tp), 1'(eu), 1'(er)};
    endfunction

    task automatic check(input string name, input logic [10:0] exp);
        logic [10:0] a;
        a = act();
        checks++;
        if (a !== exp) begin
            errors++;
            $display("FAIL %s: got go/cnt/fu/em/tp/eu/er=%b_%0d_%b%b%b%b%b expected %b_%0d_%b%b%b%b%b",
                     name, a[10], a[9:5], a[4], a[3], a[2], a[1], a[0],
                     exp[10], exp[9:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic model_step(input bit r, input bit q, input bit en, input bit ex);
        bit was_full;
        if (r) begin
            m_open = 0; m_age = 0; m_guard_left = 0; m_count = 0;
            m_tp = 0; m_eu = 0; m_er = 0;
            return;
        end
        was_full = (m_count == CAP);
        if (en && !ex) begin
            if (m_count == CAP) m_er = 1; else m_count++;
        end
        if (ex && !en) begin
            if (m_count == 0) m_er = 1; else m_count--;
        end
        if (en && !m_open) m_eu = 1;
        m_tp = 0;
        if (m_open) begin
            if (en) begin
                m_open = 0; m_guard_left = GRD;
            end else if (m_age == TMO - 1) begin
                m_open = 0; m_guard_left = GRD; m_tp = 1;
            end else begin
                m_age++;
            end
        end else if (m_guard_left > 0) begin
            m_guard_left--;
        end else if (q && !was_full) begin
            m_open = 1; m_age = 0;
        end
    endtask

    task automatic tick(input bit r, input bit q, input bit en, input bit ex);
        reset     = r;
        bus.req   = q;
        bus.enter = en;
        bus.exit  = ex;
        @(posedge clk);
        #1;
        if (model_on) model_step(r, q, en, ex);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi_cnt, tp_cnt, waited;
        bit seen_low;

        reset = 1'b1; bus.req = 1'b0; bus.enter = 1'b0; bus.exit = 1'b0;

        // Normal entry, guard hold, underflow and simultaneous-at-empty.
        tbl[0]  = '{4'b1000, 11'b0_00000_0_1_000};
        tbl[1]  = '{4'b0100, 11'b1_00000_0_1_000};
        tbl[2]  = '{4'b0000, 11'b1_00000_0_1_000};
        tbl[3]  = '{4'b0000, 11'b1_00000_0_1_000};
        tbl[4]  = '{4'b0010, 11'b0_00001_0_0_000};
        tbl[5]  = '{4'b0100, 11'b0_00001_0_0_000};
        tbl[6]  = '{4'b0100, 11'b0_00001_0_0_000};
        tbl[7]  = '{4'b0100, 11'b0_00001_0_0_000};
        tbl[8]  = '{4'b0100, 11'b0_00001_0_0_000};
        tbl[9]  = '{4'b0100, 11'b1_00001_0_0_000};
        tbl[10] = '{4'b0001, 11'b1_00000_0_1_000};
        tbl[11] = '{4'b0001, 11'b1_00000_0_1_001};
        tbl[12] = '{4'b0011, 11'b0_00000_0_1_001};
        tbl[13] = '{4'b0010, 11'b0_00001_0_0_011};
        tbl[14] = '{4'b1000, 11'b0_00000_0_1_000};

        for (int i = 0; i < 15; i++) begin
            tick(tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Timeout: gate open exactly TMO cycles, one timeout pulse.
        tick(0, 1, 0, 0);
        hi_cnt = 0; tp_cnt = 0; seen_low = 0;
        for (int i = 0; i < 300; i++) begin
            if (bus.gate_open) hi_cnt++;
            if (bus.timeout_pulse) tp_cnt++;
            if (!bus.gate_open && !seen_low) begin
                seen_low = 1;
                check("timeout_close", e(0, 0, 1, 0, 0));
            end
            tick(0, 0, 0, 0);
        end
        check_int("timeout_open_cycles", hi_cnt, TMO);
        check_int("timeout_pulse_cycles", tp_cnt, 1);
        check("timeout_after", e(0, 0, 0, 0, 0));

        // Enter on the last open cycle beats the timeout.
        tick(0, 1, 0, 0);
        idle(TMO - 1);
        check("prio_still_open", e(1, 0, 0, 0, 0));
        tick(0, 0, 1, 0);
        check("prio_enter", e(0, 1, 0, 0, 0));
        // req held through guard: reopens only once guard and idle have passed.
        waited = 0;
        while (!bus.gate_open && waited < 20) begin
            tick(0, 1, 0, 0);
            waited++;
        end
        check_int("guard_reopen_wait", waited, GRD + 1);
        tick(0, 0, 1, 0);
        check("guard_enter2", e(0, 2, 0, 0, 0));
        idle(GRD + 1);

        // Fill and block.
        tick(1, 0, 0, 0);
        for (int i = 0; i < CAP; i++) begin
            tick(0, 1, 0, 0);
            tick(0, 0, 1, 0);
            idle(GRD);
        end
        check("fill_full", e(0, CAP, 0, 0, 0));
        tick(0, 1, 0, 0);
        check("full_req_blocked", e(0, CAP, 0, 0, 0));
        tick(0, 1, 0, 0);
        check("full_req_blocked2", e(0, CAP, 0, 0, 0));
        tick(0, 0, 1, 1);
        check("full_enter_exit", e(0, CAP, 0, 1, 0));
        tick(0, 0, 1, 0);
        check("full_forced_enter", e(0, CAP, 0, 1, 1));
        tick(0, 0, 0, 1);
        check("full_exit", e(0, CAP - 1, 0, 1, 1));

        // Simultaneous at count 5.
        tick(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(0, 0, 1, 0);
        check("cnt5", e(0, 5, 0, 1, 0));
        tick(0, 0, 1, 1);
        check("cnt5_enter_exit", e(0, 5, 0, 1, 0));

        // Reset mid-OPEN at count 7.
        tick(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) tick(0, 0, 1, 0);
        idle(GRD + 1);
        tick(0, 1, 0, 0);
        check("open_cnt7", e(1, 7, 0, 1, 0));
        tick(1, 1, 0, 0);
        check("reset_mid_open", e(0, 0, 0, 0, 0));

        // Random traffic against the model.
        model_on = 1'b1;
        tick(1, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            bit r, q, en, ex;
            r  = ($urandom_range(0, 599) == 0);
            q  = ($urandom_range(0, 1) == 1);
            en = ($urandom_range(0, 99) < 15);
            ex = ($urandom_range(0, 99) < 13);
            tick(r, q, en, ex);
            check($sformatf("rand%0d", i),
                  e(int'(m_open), m_count, int'(m_tp), int'(m_eu), int'(m_er)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
